lcd_pixel_unpacker: RTL and testbench

Parametrised pixel unpacker that replaces the fixed 32-bit pixel serializer. It pulls packed frame-buffer words from the DMA FIFO and unpacks them into one pixel per handshake. Supported depths are 1/2/4/8/16/24 bpp, with selectable byte and pixel ordering. It tracks line and frame position and reports underflow. The block sits between dma_fifo_ctrl_logic and the palette/output stage, entirely in the HCLK domain; the timing controller paces it through pix_ready.

---
 rtl/lcd_pixel_unpacker.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_pixel_unpacker.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pixel_unpacker
// Description : Pulls packed frame-buffer words from the DMA FIFO and emits
//               one pixel per handshake. Supports 1/2/4/8/16/24 bpp with
//               selectable byte order (bebo) and pixel order (bepo). Tracks
//               the x/y panel position, flags end of line and end of frame,
//               and reports underflow and reserved-depth configuration.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   HCLK, HRESET      clock, synchronous active-high reset
//   en                unpacker enable (LCDEN)
//   cfg_bpp           0..5 = 1,2,4,8,16,24 bpp; 6,7 reserved (behave as 8)
//   cfg_bebo          reverse byte order of each word before unpacking
//   cfg_bepo          0 = pixel 0 at word LSBs, 1 = pixel 0 at word MSBs
//   cfg_ppl, cfg_lpp  pixels per line - 1, lines per frame - 1
//   word_valid/data   FIFO word in; word_ready pulls it this cycle
//   pix_valid/ready   pixel handshake; pix_data right-justified, zero-ext
//   pix_eol, pix_eof  current pixel closes its line / its frame
//   underflow         sticky: pixel requested while none held mid-frame
//   cfg_err           sticky: reserved cfg_bpp was latched
// WORD_W must be 32 or 64.
// ============================================================================
module lcd_pixel_unpacker #(
    parameter int WORD_W = 32,
    parameter int PPL_W  = 12,
    parameter int LPP_W  = 11
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              en,
    input  logic [2:0]        cfg_bpp,
    input  logic              cfg_bebo,
    input  logic              cfg_bepo,
    input  logic [PPL_W-1:0]  cfg_ppl,
    input  logic [LPP_W-1:0]  cfg_lpp,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              underflow,
    output logic              cfg_err
);

    localparam int          c_IDX_W    = $clog2(WORD_W);
    localparam int          c_NBYTES   = WORD_W / 8;
    localparam logic [15:0] c_WORD_W16 = 16'(WORD_W);

    // Latched configuration. r_lb is log2 of the slot width in bits
    // (24 bpp uses a 32-bit slot, so lb=5); reserved depths map to 8 bpp.
    logic [2:0]        r_lb;
    logic              r_bebo;
    logic              r_bepo;
    logic [PPL_W-1:0]  r_ppl;
    logic [LPP_W-1:0]  r_lpp;

    logic              r_en_d;
    logic [WORD_W-1:0] r_word;
    logic              r_full;
    logic [c_IDX_W-1:0] r_idx;
    logic [PPL_W-1:0]  r_x;
    logic [LPP_W-1:0]  r_y;
    logic              r_started;
    logic              r_underflow;
    logic              r_cfg_err;

    logic [WORD_W-1:0] w_word_rev;
    logic [WORD_W-1:0] w_word_ord;
    logic [15:0]       w_idx16;
    logic [15:0]       w_ppw;
    logic [15:0]       w_shift;
    logic [23:0]       w_slice;
    logic [23:0]       w_mask;
    logic              w_last;
    logic              w_xfer;
    logic              w_eol;
    logic              w_eof;
    logic              w_rise;
    logic              w_latch;
    logic              w_reserved;

    genvar gb;
    generate
        for (gb = 0; gb < c_NBYTES; gb++) begin : g_byte_rev
            assign w_word_rev[8*gb +: 8] = r_word[WORD_W-8*(gb+1) +: 8];
        end
    endgenerate

    assign w_word_ord = r_bebo ? w_word_rev : r_word;

    // Slot offset is idx << lb from the LSB end, or mirrored from the MSB
    // end when pixel 0 sits at the top of the word.
    assign w_idx16 = 16'(r_idx);
    assign w_ppw   = c_WORD_W16 >> r_lb;
    assign w_last  = (w_idx16 == (w_ppw - 16'd1));
    assign w_shift = r_bepo ? (c_WORD_W16 - ((w_idx16 + 16'd1) << r_lb))
                            : (w_idx16 << r_lb);
    assign w_slice = 24'(w_word_ord >> w_shift);

    // The 32-bit slot of 24 bpp keeps only its lower 24 bits.
    always_comb begin
        case (r_lb)
            3'd0:    w_mask = 24'h000001;
            3'd1:    w_mask = 24'h000003;
            3'd2:    w_mask = 24'h00000F;
            3'd3:    w_mask = 24'h0000FF;
            3'd4:    w_mask = 24'h00FFFF;
            default: w_mask = 24'hFFFFFF;
        endcase
    end

    assign w_xfer     = r_full & pix_ready;
    assign w_eol      = r_full & (r_x == r_ppl);
    assign w_eof      = w_eol & (r_y == r_lpp);
    assign w_rise     = en & ~r_en_d;
    assign w_latch    = w_rise | (w_xfer & w_eof);
    assign w_reserved = (cfg_bpp > 3'd5);

    // An EOL transfer discards the rest of the held word, so it frees the
    // holding register just like the last pixel of the word does.
    assign word_ready = ~HRESET & en & word_valid &
                        (~r_full | (w_xfer & (w_last | w_eol)));

    assign pix_valid = r_full;
    assign pix_data  = r_full ? (w_slice & w_mask) : 24'd0;
    assign pix_eol   = w_eol;
    assign pix_eof   = w_eof;
    assign underflow = r_underflow;
    assign cfg_err   = r_cfg_err;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_lb        <= 3'd0;
            r_bebo      <= 1'b0;
            r_bepo      <= 1'b0;
            r_ppl       <= '0;
            r_lpp       <= '0;
            r_en_d      <= 1'b0;
            r_word      <= '0;
            r_full      <= 1'b0;
            r_idx       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_started   <= 1'b0;
            r_underflow <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_en_d <= en;
            if (!en) begin
                r_full    <= 1'b0;
                r_idx     <= '0;
                r_x       <= '0;
                r_y       <= '0;
                r_started <= 1'b0;
            end else begin
                if (w_latch) begin
                    r_lb   <= w_reserved ? 3'd3 : cfg_bpp;
                    r_bebo <= cfg_bebo;
                    r_bepo <= cfg_bepo;
                    r_ppl  <= cfg_ppl;
                    r_lpp  <= cfg_lpp;
                    if (w_reserved) begin
                        r_cfg_err <= 1'b1;
                    end
                end

                if (w_rise) begin
                    r_underflow <= 1'b0;
                end else if (pix_ready & ~r_full & r_started) begin
                    r_underflow <= 1'b1;
                end

                if (w_xfer) begin
                    if (w_eol) begin
                        r_x <= '0;
                        r_y <= w_eof ? '0 : r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                    r_started <= ~w_eof;
                end

                // A word accepted alongside the EOF transfer is unpacked
                // with the configuration latched at this same edge.
                if (word_ready) begin
                    r_word <= word_data;
                    r_full <= 1'b1;
                    r_idx  <= '0;
                end else if (w_xfer) begin
                    if (w_last | w_eol) begin
                        r_full <= 1'b0;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_pixel_unpacker
// Description : Self-checking bench for lcd_pixel_unpacker. Runs a 32-bit and
//               a 64-bit instance side by side on shared stimulus; sel picks
//               which one is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  cfg_bpp;
    logic        cfg_bebo;
    logic        cfg_bepo;
    logic [11:0] cfg_ppl;
    logic [10:0] cfg_lpp;
    logic        word_valid;
    logic [63:0] word_data64;
    logic        pix_ready;
    logic        sel;

    logic        wr32, pv32, eol32, eof32, uf32, ce32;
    logic        wr64, pv64, eol64, eof64, uf64, ce64;
    logic [23:0] pd32, pd64;

    logic        o_wr, o_pv, o_eol, o_eof, o_uf, o_ce;
    logic [23:0] o_pd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_pixel_unpacker #(.WORD_W(32), .PPL_W(12), .LPP_W(11)) u_dut32 (
        .HCLK(clk), .HRESET(rst), .en(en), .cfg_bpp(cfg_bpp),
        .cfg_bebo(cfg_bebo), .cfg_bepo(cfg_bepo), .cfg_ppl(cfg_ppl),
        .cfg_lpp(cfg_lpp), .word_valid(word_valid),
        .word_data(word_data64[31:0]), .word_ready(wr32), .pix_valid(pv32),
        .pix_ready(pix_ready), .pix_data(pd32), .pix_eol(eol32),
        .pix_eof(eof32), .underflow(uf32), .cfg_err(ce32)
    );

    lcd_pixel_unpacker #(.WORD_W(64), .PPL_W(12), .LPP_W(11)) u_dut64 (
        .HCLK(clk), .HRESET(rst), .en(en), .cfg_bpp(cfg_bpp),
        .cfg_bebo(cfg_bebo), .cfg_bepo(cfg_bepo), .cfg_ppl(cfg_ppl),
        .cfg_lpp(cfg_lpp), .word_valid(word_valid),
        .word_data(word_data64), .word_ready(wr64), .pix_valid(pv64),
        .pix_ready(pix_ready), .pix_data(pd64), .pix_eol(eol64),
        .pix_eof(eof64), .underflow(uf64), .cfg_err(ce64)
    );

    assign o_wr  = sel ? wr64  : wr32;
    assign o_pv  = sel ? pv64  : pv32;
    assign o_pd  = sel ? pd64  : pd32;
    assign o_eol = sel ? eol64 : eol32;
    assign o_eof = sel ? eof64 : eof32;
    assign o_uf  = sel ? uf64  : uf32;
    assign o_ce  = sel ? ce64  : ce32;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int bpp, input bit bebo, input bit bepo,
                           input int ppl, input int lpp);
        cfg_bpp  = 3'(bpp);
        cfg_bebo = bebo;
        cfg_bepo = bepo;
        cfg_ppl  = 12'(ppl);
        cfg_lpp  = 11'(lpp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of the pixels still held, plus x/y counts.
    // ------------------------------------------------------------------
    logic [23:0] held[$];
    int  mx, my, m_bpp, m_ppl, m_lpp;
    bit  m_bebo, m_bepo, m_started, m_uf, m_cfg_err, m_en_prev;

    function automatic int bpp_bits(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 8;
            4: return 16;
            5: return 32;
            default: return 8;
        endcase
    endfunction

    function automatic void model_latch();
        m_bpp  = int'(cfg_bpp);
        m_bebo = cfg_bebo;
        m_bepo = cfg_bepo;
        m_ppl  = int'(cfg_ppl);
        m_lpp  = int'(cfg_lpp);
        if (cfg_bpp > 3'd5) m_cfg_err = 1'b1;
    endfunction

    function automatic void load_word(input int w, input logic [63:0] word);
        logic [63:0] src;
        logic [63:0] b;
        logic [63:0] v;
        int bits;
        int sh;
        src = (w == 32) ? {32'd0, word[31:0]} : word;
        b = src;
        if (m_bebo) begin
            for (int k = 0; k < w / 8; k++) b[8*k +: 8] = src[w-8*(k+1) +: 8];
        end
        bits = bpp_bits(m_bpp);
        held.delete();
        for (int i = 0; i < w / bits; i++) begin
            sh = m_bepo ? (w - (i + 1) * bits) : (i * bits);
            v = (b >> sh) & ((bits == 32) ? 64'hFF_FFFF : ((64'd1 << bits) - 64'd1));
            held.push_back(v[23:0]);
        end
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; word_valid = 1'b1; pix_ready = 1'b1;
        word_data64 = 64'h0000_0000_4433_2211; sel = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) clk1();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({o_wr, o_pv, o_pd, o_eol, o_eof, o_uf, o_ce} !== 30'd0) begin
                errors++;
                $display("FAIL reset_outputs[w%0d]: got %h expected 0", s ? 64 : 32,
                         {o_wr, o_pv, o_pd, o_eol, o_eof, o_uf, o_ce});
            end
        end
        sel = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (o_wr !== 1'b1) begin
            errors++; $display("FAIL reset_release_word_ready: got %b expected 1", o_wr);
        end
        en = 1'b0;
        clk1();
    endtask

    task automatic test_order(input bit bebo, input bit bepo,
                              input logic [95:0] exp_seq, input logic [23:0] exp_next);
        sel = 1'b0; en = 1'b0; clk1();
        set_cfg(3, bebo, bepo, 7, 0);
        word_data64 = 64'h4433_2211; word_valid = 1'b1; pix_ready = 1'b1; en = 1'b1;
        #1;
        checks++;
        if (o_wr !== 1'b1) begin
            errors++; $display("FAIL order_first_ready: got %b expected 1", o_wr);
        end
        clk1();
        word_data64 = 64'h8877_6655;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o_pv !== 1'b1 || o_pd !== exp_seq[24*i +: 24]) begin
                errors++;
                $display("FAIL order_pixel[bebo=%0d bepo=%0d i=%0d]: got v=%b d=%h expected v=1 d=%h",
                         bebo, bepo, i, o_pv, o_pd, exp_seq[24*i +: 24]);
            end
            checks++;
            if (o_wr !== (i == 3)) begin
                errors++;
                $display("FAIL order_word_ready[i=%0d]: got %b expected %b", i, o_wr, (i == 3));
            end
            clk1();
        end
        #1;
        checks++;
        if (o_pv !== 1'b1 || o_pd !== exp_next) begin
            errors++;
            $display("FAIL order_next_word: got v=%b d=%h expected v=1 d=%h", o_pv, o_pd, exp_next);
        end
        en = 1'b0;
        clk1();
        checks++;
        if (o_pv !== 1'b0 || o_eol !== 1'b0) begin
            errors++; $display("FAIL order_disable: got v=%b eol=%b expected 0 0", o_pv, o_eol);
        end
    endtask

    task automatic test_1bpp_lines();
        bit e_eol;
        sel = 1'b0; en = 1'b0; clk1();
        set_cfg(0, 0, 0, 9, 1);
        word_data64 = 64'h0000_03FF; word_valid = 1'b1; pix_ready = 1'b1; en = 1'b1;
        clk1();
        for (int k = 0; k < 21; k++) begin
            #1;
            e_eol = (k == 9) || (k == 19);
            checks++;
            if (o_pv !== 1'b1 || o_pd !== 24'h000001) begin
                errors++;
                $display("FAIL 1bpp_pixel[%0d]: got v=%b d=%h expected v=1 d=000001", k, o_pv, o_pd);
            end
            checks++;
            if (o_eol !== e_eol || o_eof !== (k == 19)) begin
                errors++;
                $display("FAIL 1bpp_eol_eof[%0d]: got %b%b expected %b%b", k, o_eol, o_eof, e_eol, (k == 19));
            end
            checks++;
            if (o_wr !== e_eol) begin
                errors++;
                $display("FAIL 1bpp_word_ready[%0d]: got %b expected %b", k, o_wr, e_eol);
            end
            clk1();
        end
        en = 1'b0;
        clk1();
    endtask

    task automatic test_24bpp_stall();
        logic        pr_tab  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        v_tab   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [23:0] d_tab   [7] = '{24'h123456, 24'h123456, 24'h123456, 24'hABCDEF,
                                     24'hABCDEF, 24'h000000, 24'h000000};
        logic        end_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        sel = 1'b1; en = 1'b0; clk1();
        set_cfg(5, 0, 0, 1, 0);
        word_data64 = 64'h00AB_CDEF_0012_3456; word_valid = 1'b1; pix_ready = 1'b0; en = 1'b1;
        clk1();
        word_valid = 1'b0;
        for (int s = 0; s < 7; s++) begin
            pix_ready = pr_tab[s];
            #1;
            checks++;
            if (o_pv !== v_tab[s] || o_pd !== d_tab[s]) begin
                errors++;
                $display("FAIL 24bpp_data[%0d]: got v=%b d=%h expected v=%b d=%h",
                         s, o_pv, o_pd, v_tab[s], d_tab[s]);
            end
            checks++;
            if (o_eol !== end_tab[s] || o_eof !== end_tab[s] || o_uf !== 1'b0) begin
                errors++;
                $display("FAIL 24bpp_flags[%0d]: got eol=%b eof=%b uf=%b expected %b %b 0",
                         s, o_eol, o_eof, o_uf, end_tab[s], end_tab[s]);
            end
            clk1();
        end
        en = 1'b0; sel = 1'b0;
        clk1();
    endtask

    task automatic test_underflow_disable();
        logic [23:0] seq [4] = '{24'h11, 24'h22, 24'h33, 24'h44};
        sel = 1'b0; en = 1'b0; clk1();
        set_cfg(3, 0, 0, 15, 0);
        word_data64 = 64'h4433_2211; word_valid = 1'b1; pix_ready = 1'b1; en = 1'b1;
        clk1();
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o_pd !== seq[i]) begin
                errors++; $display("FAIL uf_pixel[%0d]: got %h expected %h", i, o_pd, seq[i]);
            end
            clk1();
        end
        #1;
        checks++;
        if (o_pv !== 1'b0 || o_uf !== 1'b0) begin
            errors++; $display("FAIL uf_before_set: got v=%b uf=%b expected 0 0", o_pv, o_uf);
        end
        clk1();
        checks++;
        if (o_pv !== 1'b0 || o_uf !== 1'b1) begin
            errors++; $display("FAIL uf_set: got v=%b uf=%b expected 0 1", o_pv, o_uf);
        end
        word_valid = 1'b1; word_data64 = 64'h8877_6655;
        clk1();
        word_valid = 1'b0; pix_ready = 1'b0;
        #1;
        checks++;
        if (o_pv !== 1'b1 || o_pd !== 24'h55 || o_uf !== 1'b1 || o_eol !== 1'b0) begin
            errors++;
            $display("FAIL uf_resume: got v=%b d=%h uf=%b eol=%b expected 1 55 1 0", o_pv, o_pd, o_uf, o_eol);
        end
        en = 1'b0;
        clk1();
        checks++;
        if (o_pv !== 1'b0 || o_eol !== 1'b0 || o_uf !== 1'b1) begin
            errors++;
            $display("FAIL disable_midword: got v=%b eol=%b uf=%b expected 0 0 1", o_pv, o_eol, o_uf);
        end
        set_cfg(3, 0, 0, 1, 0);
        word_data64 = 64'h4433_2211; word_valid = 1'b1; pix_ready = 1'b1; en = 1'b1;
        clk1();
        checks++;
        if (o_uf !== 1'b0 || o_pv !== 1'b1 || o_pd !== 24'h11 || o_eol !== 1'b0) begin
            errors++;
            $display("FAIL reenable_first: got uf=%b v=%b d=%h eol=%b expected 0 1 11 0", o_uf, o_pv, o_pd, o_eol);
        end
        clk1();
        checks++;
        if (o_pd !== 24'h22 || o_eol !== 1'b1 || o_eof !== 1'b1) begin
            errors++;
            $display("FAIL reenable_eof: got d=%h eol=%b eof=%b expected 22 1 1", o_pd, o_eol, o_eof);
        end
        en = 1'b0; word_valid = 1'b0;
        clk1();
    endtask

    task automatic test_cfg_err();
        logic [23:0] seq [3] = '{24'h11, 24'h22, 24'h33};
        sel = 1'b0; en = 1'b0; clk1();
        set_cfg(6, 0, 0, 15, 0);
        word_data64 = 64'h4433_2211; word_valid = 1'b1; pix_ready = 1'b1; en = 1'b1;
        clk1();
        word_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_ce !== 1'b1 || o_pd !== seq[i]) begin
                errors++;
                $display("FAIL cfg_err_8bpp[%0d]: got ce=%b d=%h expected 1 %h", i, o_ce, o_pd, seq[i]);
            end
            clk1();
        end
        en = 1'b0;
        clk1();
    endtask

    task automatic test_random();
        bit          e_valid, e_eol, e_eof, e_wr, xfer;
        logic [23:0] e_data;
        int          w;
        m_uf = 1'b0;
        m_cfg_err = 1'b1;
        for (int r = 0; r < 6; r++) begin
            sel = r[0];
            w = sel ? 64 : 32;
            en = 1'b0;
            set_cfg($urandom_range(0, 5), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 5), $urandom_range(0, 2));
            clk1();
            held.delete(); mx = 0; my = 0; m_started = 1'b0; m_en_prev = 1'b0;
            for (int c = 0; c < 200; c++) begin
                en          = (c == 0) || ($urandom_range(0, 63) != 0);
                word_valid  = $urandom_range(0, 3) != 0;
                pix_ready   = $urandom_range(0, 3) != 0;
                word_data64 = {$urandom, $urandom};
                if ($urandom_range(0, 15) == 0)
                    set_cfg($urandom_range(0, 5), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                            $urandom_range(0, 5), $urandom_range(0, 2));
                #1;
                e_valid = held.size() != 0;
                e_data  = e_valid ? held[0] : 24'd0;
                e_eol   = e_valid && (mx == m_ppl);
                e_eof   = e_eol && (my == m_lpp);
                xfer    = e_valid && pix_ready;
                e_wr    = en && word_valid && (!e_valid || (xfer && (held.size() == 1 || e_eol)));
                checks++;
                if (o_pv !== e_valid || o_pd !== e_data) begin
                    errors++;
                    $display("FAIL rand_pixel[w%0d run%0d cyc%0d]: got v=%b d=%h expected v=%b d=%h",
                             w, r, c, o_pv, o_pd, e_valid, e_data);
                end
                checks++;
                if (o_eol !== e_eol || o_eof !== e_eof) begin
                    errors++;
                    $display("FAIL rand_eol_eof[w%0d run%0d cyc%0d]: got %b%b expected %b%b",
                             w, r, c, o_eol, o_eof, e_eol, e_eof);
                end
                checks++;
                if (o_wr !== e_wr) begin
                    errors++;
                    $display("FAIL rand_word_ready[w%0d run%0d cyc%0d]: got %b expected %b", w, r, c, o_wr, e_wr);
                end
                checks++;
                if (o_uf !== m_uf || o_ce !== m_cfg_err) begin
                    errors++;
                    $display("FAIL rand_flags[w%0d run%0d cyc%0d]: got uf=%b ce=%b expected %b %b",
                             w, r, c, o_uf, o_ce, m_uf, m_cfg_err);
                end
                if (!en) begin
                    held.delete(); mx = 0; my = 0; m_started = 1'b0;
                end else begin
                    if (!m_en_prev) begin
                        model_latch();
                        m_uf = 1'b0;
                    end else if (pix_ready && !e_valid && m_started) begin
                        m_uf = 1'b1;
                    end
                    if (xfer) begin
                        void'(held.pop_front());
                        if (e_eol) begin
                            held.delete();
                            mx = 0;
                            if (e_eof) begin
                                my = 0;
                                model_latch();
                            end else begin
                                my++;
                            end
                        end else begin
                            mx++;
                        end
                        m_started = !e_eof;
                    end
                    if (e_wr) load_word(w, word_data64);
                end
                m_en_prev = en;
                clk1();
            end
        end
        en = 1'b0;
        clk1();
    endtask

    initial begin
        test_reset();
        test_order(1'b0, 1'b0, {24'h44, 24'h33, 24'h22, 24'h11}, 24'h55);
        test_order(1'b1, 1'b1, {24'h44, 24'h33, 24'h22, 24'h11}, 24'h55);
        test_order(1'b0, 1'b1, {24'h11, 24'h22, 24'h33, 24'h44}, 24'h88);
        test_order(1'b1, 1'b0, {24'h11, 24'h22, 24'h33, 24'h44}, 24'h88);
        test_1bpp_lines();
        test_24bpp_stall();
        test_underflow_disable();
        test_cfg_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
